// File: rtl/mem_req_arbiter_if.sv
// Bundle of requester, memory-controller and global-control signals seen by
// mem_req_arbiter. The master modport is the arbiter's own view (it drives the
// controller request and the completion pulses); the slave modport is the
// view of the surrounding requesters and controller.
interface mem_req_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              rdy;
    logic              iIO_buffer_full;
    logic              iFLUSH;

    logic              iIF_req;
    logic [ADDR_W-1:0] iIF_addr;
    logic              oIF_done;
    logic [DATA_W-1:0] oIF_inst;

    logic              iLD_req;
    logic [ADDR_W-1:0] iLD_addr;
    logic [2:0]        iLD_len;
    logic              oLD_done;
    logic [DATA_W-1:0] oLD_dt;

    logic              iST_req;
    logic [ADDR_W-1:0] iST_addr;
    logic [2:0]        iST_len;
    logic [DATA_W-1:0] iST_dt;
    logic              oST_done;

    logic              oMC_en;
    logic              oMC_ls;
    logic [2:0]        oMC_len;
    logic [ADDR_W-1:0] oMC_addr;
    logic [DATA_W-1:0] oMC_dt;
    logic              iMC_done;
    logic [DATA_W-1:0] iMC_dt;

    modport master (
        input  rdy, iIO_buffer_full, iFLUSH,
        input  iIF_req, iIF_addr,
        output oIF_done, oIF_inst,
        input  iLD_req, iLD_addr, iLD_len,
        output oLD_done, oLD_dt,
        input  iST_req, iST_addr, iST_len, iST_dt,
        output oST_done,
        output oMC_en, oMC_ls, oMC_len, oMC_addr, oMC_dt,
        input  iMC_done, iMC_dt
    );

    modport slave (
        output rdy, iIO_buffer_full, iFLUSH,
        output iIF_req, iIF_addr,
        input  oIF_done, oIF_inst,
        output iLD_req, iLD_addr, iLD_len,
        input  oLD_done, oLD_dt,
        output iST_req, iST_addr, iST_len, iST_dt,
        input  oST_done,
        input  oMC_en, oMC_ls, oMC_len, oMC_addr, oMC_dt,
        output iMC_done, iMC_dt
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Fixed-priority arbiter (store > load > fetch) in front of a one-request-at-
// a-time memory controller. Holds the grant until the controller completes,
// returns a one-cycle done pulse with data, discards fetches hit by a flush
// and holds back I/O stores while the UART buffer is full.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_req_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    mem_req_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, BUSY_IF, BUSY_LD, BUSY_ST, DRAIN} state_t;

    state_t            state_q, state_d;
    logic              mc_en_q, mc_en_d;
    logic              mc_ls_q, mc_ls_d;
    logic [2:0]        mc_len_q, mc_len_d;
    logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
    logic [DATA_W-1:0] mc_dt_q, mc_dt_d;
    logic              if_done_q, if_done_d;
    logic              ld_done_q, ld_done_d;
    logic              st_done_q, st_done_d;
    logic [DATA_W-1:0] if_inst_q, if_inst_d;
    logic [DATA_W-1:0] ld_dt_q, ld_dt_d;

    logic              if_elig, ld_elig, st_elig, if_promote, grant_if;
    logic [DATA_W-1:0] ld_mask;

    // A requester whose done pulse is showing is masked so the same request
    // is not re-granted in the bubble cycle.
    assign if_elig = bus.iIF_req && !bus.iFLUSH && !if_done_q;
    assign ld_elig = bus.iLD_req && !ld_done_q;
    assign st_elig = bus.iST_req && !st_done_q &&
                     !((bus.iST_addr[17:16] == 2'b11) && bus.iIO_buffer_full);

    // Loads are returned zero-extended to their byte length.
    assign ld_mask = (mc_len_q == 3'd1) ? DATA_W'(8'hFF)   :
                     (mc_len_q == 3'd2) ? DATA_W'(16'hFFFF) : '1;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q, starve_d;
    assign if_promote = if_elig && (starve_q == SW'(STARVE_LIMIT));
`else
    assign if_promote = 1'b0;
`endif

    // Next-state, grant and completion logic.
    always_comb begin
        state_d   = state_q;
        mc_en_d   = mc_en_q;
        mc_ls_d   = mc_ls_q;
        mc_len_d  = mc_len_q;
        mc_addr_d = mc_addr_q;
        mc_dt_d   = mc_dt_q;
        if_done_d = 1'b0;
        ld_done_d = 1'b0;
        st_done_d = 1'b0;
        if_inst_d = if_inst_q;
        ld_dt_d   = ld_dt_q;
        grant_if  = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_promote || (if_elig && !st_elig && !ld_elig)) begin
                    grant_if  = 1'b1;
                    state_d   = BUSY_IF;
                    mc_en_d   = 1'b1;
                    mc_ls_d   = 1'b0;
                    mc_len_d  = 3'd4;
                    mc_addr_d = bus.iIF_addr;
                    mc_dt_d   = '0;
                end else if (st_elig) begin
                    state_d   = BUSY_ST;
                    mc_en_d   = 1'b1;
                    mc_ls_d   = 1'b1;
                    mc_len_d  = bus.iST_len;
                    mc_addr_d = bus.iST_addr;
                    mc_dt_d   = bus.iST_dt;
                end else if (ld_elig) begin
                    state_d   = BUSY_LD;
                    mc_en_d   = 1'b1;
                    mc_ls_d   = 1'b0;
                    mc_len_d  = bus.iLD_len;
                    mc_addr_d = bus.iLD_addr;
                    mc_dt_d   = '0;
                end
            end
            BUSY_IF: begin
                if (bus.iMC_done) begin
                    state_d = IDLE;
                    mc_en_d = 1'b0;
                    // A flush landing with the completion drops the word.
                    if (!bus.iFLUSH) begin
                        if_done_d = 1'b1;
                        if_inst_d = bus.iMC_dt;
                    end
                end else if (bus.iFLUSH) begin
                    state_d = DRAIN;
                end
            end
            BUSY_LD: begin
                if (bus.iMC_done) begin
                    state_d   = IDLE;
                    mc_en_d   = 1'b0;
                    ld_done_d = 1'b1;
                    ld_dt_d   = bus.iMC_dt & ld_mask;
                end
            end
            BUSY_ST: begin
                if (bus.iMC_done) begin
                    state_d   = IDLE;
                    mc_en_d   = 1'b0;
                    st_done_d = 1'b1;
                end
            end
            DRAIN: begin
                // The controller cannot abort; wait it out and discard.
                if (bus.iMC_done) begin
                    state_d = IDLE;
                    mc_en_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                mc_en_d = 1'b0;
            end
        endcase
`ifdef ARB_STARVE_GUARD_EN
        starve_d = starve_q;
        if (bus.iFLUSH || grant_if)
            starve_d = '0;
        else if (state_q == IDLE && if_elig && starve_q != SW'(STARVE_LIMIT))
            starve_d = starve_q + 1'b1;
`endif
    end

    // State and output registers; rdy low freezes everything, stretching
    // any done pulse until rdy returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mc_en_q   <= 1'b0;
            mc_ls_q   <= 1'b0;
            mc_len_q  <= '0;
            mc_addr_q <= '0;
            mc_dt_q   <= '0;
            if_done_q <= 1'b0;
            ld_done_q <= 1'b0;
            st_done_q <= 1'b0;
            if_inst_q <= '0;
            ld_dt_q   <= '0;
`ifdef ARB_STARVE_GUARD_EN
            starve_q  <= '0;
`endif
        end else if (bus.rdy) begin
            state_q   <= state_d;
            mc_en_q   <= mc_en_d;
            mc_ls_q   <= mc_ls_d;
            mc_len_q  <= mc_len_d;
            mc_addr_q <= mc_addr_d;
            mc_dt_q   <= mc_dt_d;
            if_done_q <= if_done_d;
            ld_done_q <= ld_done_d;
            st_done_q <= st_done_d;
            if_inst_q <= if_inst_d;
            ld_dt_q   <= ld_dt_d;
`ifdef ARB_STARVE_GUARD_EN
            starve_q  <= starve_d;
`endif
        end
    end

    assign bus.oMC_en   = mc_en_q;
    assign bus.oMC_ls   = mc_ls_q;
    assign bus.oMC_len  = mc_len_q;
    assign bus.oMC_addr = mc_addr_q;
    assign bus.oMC_dt   = mc_dt_q;
    assign bus.oIF_done = if_done_q;
    assign bus.oIF_inst = if_inst_q;
    assign bus.oLD_done = ld_done_q;
    assign bus.oLD_dt   = ld_dt_q;
    assign bus.oST_done = st_done_q;
endmodule
